// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage chain: DEPTH cascaded stages, each with a main and a skid entry.
// Optional synchronous flush is compiled in when PIPE_FLUSH_EN is defined.
module pipe_stage_skid #(
    parameter int W     = 32,
    parameter int DEPTH = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_data,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(2*DEPTH+1);

    logic [DEPTH-1:0] m_v_all;
    logic [DEPTH-1:0] s_v_all;
    logic [DEPTH-1:0] m_v_nx;
    logic [DEPTH-1:0] s_v_nx;
    logic [W-1:0]     m_d_all [DEPTH];
    logic             flush_act;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

`ifdef PIPE_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    // Stage 0 readiness depends only on its own skid register, never on out_ready.
    assign in_ready  = !s_v_all[0] && !rst && !flush_act;
    assign out_valid = m_v_all[DEPTH-1];
    assign out_data  = m_d_all[DEPTH-1];
    assign occupancy = occ_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic         m_v_q, m_v_d;
        logic         s_v_q, s_v_d;
        logic [W-1:0] m_d_q, m_d_d;
        logic [W-1:0] s_d_q, s_d_d;
        logic         up_v;
        logic [W-1:0] up_d;
        logic         dn_r;
        logic         acc;
        logic         pop;

        if (k == 0) begin : g_first
            assign up_v = in_valid && in_ready;
            assign up_d = in_data;
        end else begin : g_mid
            assign up_v = m_v_all[k-1];
            assign up_d = m_d_all[k-1];
        end

        if (k == DEPTH - 1) begin : g_last
            assign dn_r = out_ready;
        end else begin : g_inner
            assign dn_r = !s_v_all[k+1];
        end

        assign acc = up_v && !s_v_q;
        assign pop = m_v_q && dn_r;

        always_comb begin
            m_v_d = m_v_q;
            s_v_d = s_v_q;
            m_d_d = m_d_q;
            s_d_d = s_d_q;
            if (!m_v_q) begin
                if (acc) begin
                    m_v_d = 1'b1;
                    m_d_d = up_d;
                end
            end else if (!s_v_q) begin
                if (acc && pop) begin
                    m_d_d = up_d;
                end else if (acc) begin
                    s_v_d = 1'b1;
                    s_d_d = up_d;
                end else if (pop) begin
                    m_v_d = 1'b0;
                end
            end else if (pop) begin
                // Skid drains into main; upstream was held off by !s_v.
                m_d_d = s_d_q;
                s_v_d = 1'b0;
            end
            if (flush_act) begin
                m_v_d = 1'b0;
                s_v_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                m_v_q <= 1'b0;
                s_v_q <= 1'b0;
                m_d_q <= '0;
                s_d_q <= '0;
            end else begin
                m_v_q <= m_v_d;
                s_v_q <= s_v_d;
                m_d_q <= m_d_d;
                s_d_q <= s_d_d;
            end
        end

        assign m_v_all[k] = m_v_q;
        assign s_v_all[k] = s_v_q;
        assign m_d_all[k] = m_d_q;
        assign m_v_nx[k]  = m_v_d;
        assign s_v_nx[k]  = s_v_d;
    end

    // Occupancy is computed from next-state bits so the register matches the stage state after each edge.
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(m_v_nx[k]) + OCC_W'(s_v_nx[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule
